// File: rtl/shift_toggle_pkg.sv
// Shared definitions for the shift/toggle register bank.
// Mode encodings for the operation select and the bounce direction codes.
// Optional build macro: SHIFT_CARRY_EN (adds the registered carry output).
package shift_toggle_pkg;

    // Operation select encodings (3-bit)
    localparam logic [2:0] MODE_HOLD   = 3'd0;
    localparam logic [2:0] MODE_SHL    = 3'd1;
    localparam logic [2:0] MODE_SHR    = 3'd2;
    localparam logic [2:0] MODE_ROL    = 3'd3;
    localparam logic [2:0] MODE_ROR    = 3'd4;
    localparam logic [2:0] MODE_BOUNCE = 3'd5;
    localparam logic [2:0] MODE_TOGGLE = 3'd6;
    localparam logic [2:0] MODE_LOAD   = 3'd7;

    // Bounce direction: LEFT moves toward the MSB, RIGHT toward the LSB
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage : shift_toggle_pkg

// File: rtl/shift_toggle_bank_tick_prescaler.sv
// Clock-enable prescaler: produces a one-clock step strobe every DIV
// enabled clocks. The count freezes while en is low so a paused pattern
// resumes with the same phase. DIV=1 gives step == en.
module tick_prescaler
    import shift_toggle_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic step
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             at_last_s;

    assign at_last_s = (cnt_r == CNT_LAST);
    assign step      = en & at_last_s;

    // Next count: advance while enabled, wrap at DIV-1, otherwise hold
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (en) begin
            if (at_last_s) begin
                cnt_nxt_s = CNT_ZERO;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule : tick_prescaler

// File: rtl/shift_toggle_bank.sv
// WIDTH-bit LED pattern register: hold, shift, rotate, bounce, masked
// toggle and parallel load, paced by an internal step prescaler.
// LOAD acts on every clock; all other modes act only on step edges.
// Optional build macro: SHIFT_CARRY_EN adds a registered carry output that
// captures the bit shifted/rotated out of q on SHL/SHR/ROL/ROR steps.
module shift_toggle_bank
    import shift_toggle_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] t_mask,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             step
`ifdef SHIFT_CARRY_EN
    ,
    output logic             carry
`endif
);

    localparam logic [WIDTH-1:0] Q_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] Q_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             dir_r;
    logic             dir_nxt_s;
    logic             step_s;

    tick_prescaler #(
        .DIV (DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .step  (step_s)
    );

    assign step = step_s;
    assign q    = q_r;
    assign dir  = dir_r;

    // Next pattern and bounce direction; LOAD overrides the step gate
    always_comb begin
        q_nxt_s   = q_r;
        dir_nxt_s = dir_r;
        if (mode == MODE_LOAD) begin
            q_nxt_s   = load_val;
            dir_nxt_s = DIR_LEFT;
        end else if (step_s) begin
            case (mode)
                MODE_HOLD: begin
                    q_nxt_s   = q_r;
                    dir_nxt_s = dir_r;
                end
                MODE_SHL: begin
                    q_nxt_s = {q_r[WIDTH-2:0], ser_in};
                end
                MODE_SHR: begin
                    q_nxt_s = {ser_in, q_r[WIDTH-1:1]};
                end
                MODE_ROL: begin
                    q_nxt_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                end
                MODE_ROR: begin
                    q_nxt_s = {q_r[0], q_r[WIDTH-1:1]};
                end
                MODE_BOUNCE: begin
                    // Empty register self-starts at bit 0; ends detected on MSB/LSB only
                    if (q_r == Q_ZERO) begin
                        q_nxt_s   = Q_ONE;
                        dir_nxt_s = DIR_LEFT;
                    end else if ((dir_r == DIR_LEFT) && q_r[WIDTH-1]) begin
                        q_nxt_s   = q_r >> 1;
                        dir_nxt_s = DIR_RIGHT;
                    end else if (dir_r == DIR_LEFT) begin
                        q_nxt_s   = q_r << 1;
                        dir_nxt_s = DIR_LEFT;
                    end else if (q_r[0]) begin
                        q_nxt_s   = q_r << 1;
                        dir_nxt_s = DIR_LEFT;
                    end else begin
                        q_nxt_s   = q_r >> 1;
                        dir_nxt_s = DIR_RIGHT;
                    end
                end
                MODE_TOGGLE: begin
                    q_nxt_s = q_r ^ t_mask;
                end
                default: begin
                    q_nxt_s   = q_r;
                    dir_nxt_s = dir_r;
                end
            endcase
        end else begin
            q_nxt_s   = q_r;
            dir_nxt_s = dir_r;
        end
    end

    // Pattern and direction registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r   <= Q_ZERO;
            dir_r <= DIR_LEFT;
        end else begin
            q_r   <= q_nxt_s;
            dir_r <= dir_nxt_s;
        end
    end

`ifdef SHIFT_CARRY_EN
    logic carry_r;
    logic carry_nxt_s;

    assign carry = carry_r;

    // Carry captures the bit leaving q on shift/rotate steps, else holds
    always_comb begin
        carry_nxt_s = carry_r;
        if ((mode != MODE_LOAD) && step_s) begin
            case (mode)
                MODE_SHL: carry_nxt_s = q_r[WIDTH-1];
                MODE_ROL: carry_nxt_s = q_r[WIDTH-1];
                MODE_SHR: carry_nxt_s = q_r[0];
                MODE_ROR: carry_nxt_s = q_r[0];
                default:  carry_nxt_s = carry_r;
            endcase
        end else begin
            carry_nxt_s = carry_r;
        end
    end

    // Carry register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_r <= 1'b0;
        end else begin
            carry_r <= carry_nxt_s;
        end
    end
`endif

endmodule : shift_toggle_bank

// File: tb/tb_shift_toggle_bank.sv
// Directed self-checking bench for shift_toggle_bank.
// Main instance: WIDTH=8, DIV=4. Second instance: WIDTH=8, DIV=1.
// Honours SHIFT_CARRY_EN when defined.
module tb_shift_toggle_bank;
    import shift_toggle_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] load_val;
    logic       ser_in;
    logic [7:0] t_mask;
    logic [7:0] q;
    logic       dir;
    logic       step;

    logic       en1;
    logic [2:0] mode1;
    logic       ser_in1;
    logic [7:0] q1;
    logic       dir1;
    logic       step1;

`ifdef SHIFT_CARRY_EN
    logic       carry;
    logic       carry1;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_wait;

    shift_toggle_bank #(.WIDTH(8), .DIV(4)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .load_val (load_val),
        .ser_in   (ser_in),
        .t_mask   (t_mask),
        .q        (q),
        .dir      (dir),
        .step     (step)
`ifdef SHIFT_CARRY_EN
        ,
        .carry    (carry)
`endif
    );

    shift_toggle_bank #(.WIDTH(8), .DIV(1)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .en       (en1),
        .mode     (mode1),
        .load_val (8'h00),
        .ser_in   (ser_in1),
        .t_mask   (8'h00),
        .q        (q1),
        .dir      (dir1),
        .step     (step1)
`ifdef SHIFT_CARRY_EN
        ,
        .carry    (carry1)
`endif
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until step is high, then take that edge
    task automatic do_step(input string tag);
        n_wait = 0;
        while (!step && n_wait < 8) begin
            tick();
            n_wait++;
        end
        if (!step) begin
            chk({tag, "_step_timeout"}, 32'(step), 32'd1);
        end
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        mode     = MODE_HOLD;
        load_val = 8'h00;
        ser_in   = 1'b0;
        t_mask   = 8'h00;
        en1      = 1'b0;
        mode1    = MODE_HOLD;
        ser_in1  = 1'b0;
        #2;
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        en    = 1'b1;

        // LOAD takes effect on the next edge regardless of step
        mode     = MODE_LOAD;
        load_val = 8'hA5;
        tick();
        chk("load_a5", 32'(q), 32'hA5);
        chk("load_dir", 32'(dir), 32'd0);

        // ROL: q holds until the step edge, then rotates
        mode   = MODE_ROL;
        n_wait = 0;
        while (!step && n_wait < 8) begin
            tick();
            n_wait++;
        end
        chk("rol_hold_before_step", 32'(q), 32'hA5);
        tick();
        chk("rol_first", 32'(q), 32'h4B);
        n_wait = 0;
        while (!step && n_wait < 8) begin
            tick();
            n_wait++;
        end
        chk("step_period", 32'(n_wait), 32'd3);
        tick();
        chk("rol_second", 32'(q), 32'h96);

        // Freeze: en low keeps both q and the prescaler phase
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        chk("freeze_q", 32'(q), 32'h96);
        chk("freeze_step", 32'(step), 32'd0);
        en = 1'b1;
        tick();
        chk("resume_step_early", 32'(step), 32'd0);
        tick();
        chk("resume_step", 32'(step), 32'd1);
        tick();
        chk("rol_third", 32'(q), 32'h2D);

        // TOGGLE with a mask, then with a zero mask
        mode     = MODE_LOAD;
        load_val = 8'hA5;
        tick();
        mode   = MODE_TOGGLE;
        t_mask = 8'h0F;
        do_step("tog1");
        chk("toggle_1", 32'(q), 32'hAA);
        do_step("tog2");
        chk("toggle_2", 32'(q), 32'hA5);
        t_mask = 8'h00;
        do_step("tog0");
        chk("toggle_zero_mask", 32'(q), 32'hA5);

        // BOUNCE from zero: climb to the MSB, reverse, return, reverse
        mode     = MODE_LOAD;
        load_val = 8'h00;
        tick();
        mode = MODE_BOUNCE;
        for (int i = 0; i < 8; i++) begin
            do_step("bnc_up");
            chk($sformatf("bounce_up_%0d", i), 32'(q), 32'd1 << i);
            chk($sformatf("bounce_up_dir_%0d", i), 32'(dir), 32'd0);
        end
        do_step("bnc_turn");
        chk("bounce_turn_q", 32'(q), 32'h40);
        chk("bounce_turn_dir", 32'(dir), 32'd1);
        for (int i = 5; i >= 0; i--) begin
            do_step("bnc_dn");
            chk($sformatf("bounce_down_%0d", i), 32'(q), 32'd1 << i);
        end
        chk("bounce_down_dir", 32'(dir), 32'd1);
        do_step("bnc_turn2");
        chk("bounce_turn2_q", 32'(q), 32'h02);
        chk("bounce_turn2_dir", 32'(dir), 32'd0);

        // Set dir=RIGHT, then hit reset asynchronously between edges
        mode     = MODE_LOAD;
        load_val = 8'h80;
        tick();
        mode = MODE_BOUNCE;
        do_step("bnc_pre_rst");
        chk("pre_rst_q", 32'(q), 32'h40);
        chk("pre_rst_dir", 32'(dir), 32'd1);
        reset = 1'b1;
        #2;
        chk("async_rst_q", 32'(q), 32'h00);
        chk("async_rst_dir", 32'(dir), 32'd0);
        tick();
        reset = 1'b0;

        // SHR with ser_in=1 from an empty register
        mode   = MODE_SHR;
        ser_in = 1'b1;
        do_step("shr1");
        chk("shr_80", 32'(q), 32'h80);
        do_step("shr2");
        chk("shr_c0", 32'(q), 32'hC0);
        chk("shr_dir_kept", 32'(dir), 32'd0);

`ifdef SHIFT_CARRY_EN
        chk("carry_shr_zero", 32'(carry), 32'd0);
        mode     = MODE_LOAD;
        load_val = 8'h01;
        tick();
        chk("carry_hold_load", 32'(carry), 32'd0);
        mode = MODE_SHR;
        do_step("shr_carry");
        chk("carry_shr_one", 32'(carry), 32'd1);
        chk("carry_shr_q", 32'(q), 32'h80);
        mode   = MODE_SHL;
        ser_in = 1'b0;
        do_step("shl_carry");
        chk("carry_shl_msb", 32'(carry), 32'd1);
        chk("carry_shl_q", 32'(q), 32'h00);
        do_step("shl_carry0");
        chk("carry_shl_zero", 32'(carry), 32'd0);
`endif

        // DIV=1 instance: step mirrors en, SHL fills one bit per clock
        chk("div1_step_off", 32'(step1), 32'd0);
        en1     = 1'b1;
        mode1   = MODE_SHL;
        ser_in1 = 1'b1;
        #1;
        chk("div1_step_on", 32'(step1), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        chk("div1_shl_7", 32'(q1), 32'h7F);
        tick();
        chk("div1_shl_8", 32'(q1), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_shift_toggle_bank
